// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control sequencer for the MIPS datapath.
// Owns the PC and the instruction register, fetches over a valid/req handshake,
// and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with Moore control strobes.
// Optional build macro MIPS_CTRL_PERF_EN adds cycle_count / retired_count outputs.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  output logic [31:0] pc,
  input  logic        instr_valid,
  input  logic [31:0] instr_rdata,
  output logic [31:0] instruction,
  output logic        ALUScr,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic [3:0]  ALUControl,
  input  logic        Zero,
  output logic        illegal_op,
  output logic        retire
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // R-type funct decode: returns {supported, ALUControl}
  function automatic logic [4:0] r_alu(input logic [5:0] funct);
    case (funct)
      6'h24:   r_alu = {1'b1, ALU_AND};
      6'h25:   r_alu = {1'b1, ALU_OR};
      6'h20:   r_alu = {1'b1, ALU_ADD};
      6'h22:   r_alu = {1'b1, ALU_SUB};
      6'h2A:   r_alu = {1'b1, ALU_SLT};
      6'h27:   r_alu = {1'b1, ALU_NOR};
      default: r_alu = {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t      state, state_next;
  logic [31:0] ir;
  logic [31:0] pc_next;
  logic        ir_load;

  logic [5:0]  opcode;
  logic        is_r, is_lw, is_sw, is_addi, is_beq, is_j;
  logic        r_ok, legal, uses_imm;
  logic [3:0]  r_ctrl, op_alu;
  logic [31:0] pc4, br_target, j_target;

  assign instruction = ir;
  assign opcode      = ir[31:26];
  assign is_r        = (opcode == OP_R);
  assign is_lw       = (opcode == OP_LW);
  assign is_sw       = (opcode == OP_SW);
  assign is_addi     = (opcode == OP_ADDI);
  assign is_beq      = (opcode == OP_BEQ);
  assign is_j        = (opcode == OP_J);
  assign {r_ok, r_ctrl} = r_alu(ir[5:0]);
  assign legal       = (is_r && r_ok) || is_lw || is_sw || is_addi || is_beq || is_j;
  assign uses_imm    = is_lw || is_sw || is_addi;
  assign op_alu      = is_r ? r_ctrl : (is_beq ? ALU_SUB : ALU_ADD);

  // PC arithmetic is modulo 2^32; the offset is sign-extended before the word shift
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign j_target  = {pc4[31:28], ir[25:0], 2'b00};

  // State, PC and IR registers; IR only changes on the fetch handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= instr_rdata;
    end
  end

  // Next-state, next-PC and Moore control strobes decoded from state and IR
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    instr_req  = 1'b0;
    ALUScr     = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUControl = ALU_ADD;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        // request is held off while reset is asserted
        instr_req = ~rst;
        if (instr_valid) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          illegal_op = 1'b1;
          if (ILLEGAL_HALT) begin
            state_next = S_HALT;
          end else begin
            pc_next    = pc4;
            state_next = S_FETCH;
          end
        end else if (is_j) begin
          pc_next    = j_target;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ALUControl = op_alu;
        ALUScr     = uses_imm;
        RegDst     = is_r;
        if (is_beq) begin
          pc_next    = Zero ? br_target : pc4;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_next = S_MEMORY;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        ALUControl = op_alu;
        ALUScr     = uses_imm;
        if (is_sw) begin
          MemWrite   = 1'b1;
          pc_next    = pc4;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          MemRead    = 1'b1;
          state_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        ALUControl = op_alu;
        ALUScr     = uses_imm;
        RegDst     = is_r;
        MemRead    = is_lw;
        MemtoReg   = is_lw;
        RegWrite   = 1'b1;
        pc_next    = pc4;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

`ifdef MIPS_CTRL_PERF_EN
  // Free-running performance counters; cycles stop counting while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= 32'h0;
      retired_count <= 32'h0;
    end else begin
      if (state != S_HALT) cycle_count <= cycle_count + 32'd1;
      if (retire)          retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: one skip-on-illegal instance and
// one halt-on-illegal instance share clock, reset and fetch inputs.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_rdata = 32'h0;
  logic        Zero = 1'b0;

  logic        instr_req, ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg, illegal_op, retire;
  logic [31:0] pc, instruction;
  logic [3:0]  ALUControl;

  logic        h_instr_req, h_ALUScr, h_RegWrite, h_RegDst, h_MemRead, h_MemWrite, h_MemtoReg;
  logic        h_illegal_op, h_retire;
  logic [31:0] h_pc, h_instruction;
  logic [3:0]  h_ALUControl;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_count, retired_count, h_cycle_count, h_retired_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.RESET_PC(32'h0), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .pc(pc),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .instruction(instruction),
    .ALUScr(ALUScr), .RegWrite(RegWrite), .RegDst(RegDst), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUControl(ALUControl), .Zero(Zero),
    .illegal_op(illegal_op), .retire(retire)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  mips_multicycle_ctrl #(.RESET_PC(32'h0), .ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst), .instr_req(h_instr_req), .pc(h_pc),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .instruction(h_instruction),
    .ALUScr(h_ALUScr), .RegWrite(h_RegWrite), .RegDst(h_RegDst), .MemRead(h_MemRead),
    .MemWrite(h_MemWrite), .MemtoReg(h_MemtoReg), .ALUControl(h_ALUControl), .Zero(Zero),
    .illegal_op(h_illegal_op), .retire(h_retire)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_count(h_cycle_count), .retired_count(h_retired_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one word in FETCH, take the handshake, land in DECODE
  task automatic fetch(input logic [31:0] word);
    instr_valid = 1'b1;
    instr_rdata = word;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [5:0]  functs [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
  logic [3:0]  ctrls  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  logic [31:0] exp_pc;

  initial begin
    // ---------------- test 1: reset and add $3,$1,$2
    instr_valid = 1'b1;
    instr_rdata = 32'h0022_1820;
    rst = 1'b1;
    step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_ir", instruction, 32'h0);
    check_eq("rst_req", {31'h0, instr_req}, 32'h0);
    check_eq("rst_alu", {28'h0, ALUControl}, 32'h2);
    check_eq("rst_strobes", {25'h0, RegWrite, MemWrite, MemRead, illegal_op, retire, ALUScr, RegDst}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check_eq("add_c0_req", {31'h0, instr_req}, 32'h1);
    fetch(32'h0022_1820);
    check_eq("add_c1_ir", instruction, 32'h0022_1820);
    check_eq("add_c1_req", {31'h0, instr_req}, 32'h0);
    check_eq("add_c1_rw", {31'h0, RegWrite}, 32'h0);
    step();
    check_eq("add_c2_alu", {28'h0, ALUControl}, 32'h2);
    check_eq("add_c2_regdst", {31'h0, RegDst}, 32'h1);
    check_eq("add_c2_rw", {31'h0, RegWrite}, 32'h0);
    check_eq("add_c2_aluscr", {31'h0, ALUScr}, 32'h0);
    step();
    check_eq("add_c3_rw", {31'h0, RegWrite}, 32'h1);
    check_eq("add_c3_retire", {31'h0, retire}, 32'h1);
    check_eq("add_c3_memtoreg", {31'h0, MemtoReg}, 32'h0);
    step();
    check_eq("add_pc", pc, 32'h4);
    check_eq("add_c4_rw", {31'h0, RegWrite}, 32'h0);

    // ---------------- R-type ALU table and addi
    exp_pc = 32'h4;
    for (int i = 0; i < 6; i++) begin
      fetch({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, functs[i]});
      step();
      check_eq($sformatf("r_alu_ex_%0d", i), {28'h0, ALUControl}, {28'h0, ctrls[i]});
      step();
      check_eq($sformatf("r_alu_wb_%0d", i), {28'h0, ALUControl}, {28'h0, ctrls[i]});
      check_eq($sformatf("r_rw_%0d", i), {31'h0, RegWrite}, 32'h1);
      step();
      exp_pc = exp_pc + 32'd4;
      check_eq($sformatf("r_pc_%0d", i), pc, exp_pc);
    end
    fetch(32'h2005_0007);
    step();
    check_eq("addi_ex_aluscr", {31'h0, ALUScr}, 32'h1);
    check_eq("addi_ex_alu", {28'h0, ALUControl}, 32'h2);
    step();
    check_eq("addi_wb", {28'h0, RegWrite, RegDst, MemtoReg, ALUScr}, 32'b1001);
    step();
    check_eq("addi_pc", pc, 32'h20);

    // ---------------- test 2: lw then sw
    do_reset();
    fetch(32'h8C05_0008);
    check_eq("lw_c1_mr", {31'h0, MemRead}, 32'h0);
    step();
    check_eq("lw_c2_aluscr", {31'h0, ALUScr}, 32'h1);
    check_eq("lw_c2_mr", {31'h0, MemRead}, 32'h0);
    step();
    check_eq("lw_c3", {28'h0, MemRead, MemtoReg, RegWrite, ALUScr}, 32'b1001);
    step();
    check_eq("lw_c4", {27'h0, MemRead, MemtoReg, RegWrite, RegDst, retire}, 32'b11101);
    check_eq("lw_c4_alu", {28'h0, ALUControl}, 32'h2);
    step();
    check_eq("lw_pc", pc, 32'h4);
    fetch(32'hAC05_000C);
    check_eq("sw_c1", {30'h0, MemWrite, RegWrite}, 32'h0);
    step();
    check_eq("sw_c2", {30'h0, MemWrite, RegWrite}, 32'h0);
    step();
    check_eq("sw_c3", {29'h0, MemWrite, RegWrite, retire}, 32'b101);
    step();
    check_eq("sw_c4", {30'h0, MemWrite, RegWrite}, 32'h0);
    check_eq("sw_pc", pc, 32'h8);

    // ---------------- test 3: j to 0x10, beq taken/not taken, j 0x40
    fetch(32'h0800_0004);
    check_eq("j1_retire", {31'h0, retire}, 32'h1);
    step();
    check_eq("j1_pc", pc, 32'h10);
    fetch(32'h1000_FFFF);
    step();
    Zero = 1'b1;
    #1;
    check_eq("beq_t_alu", {28'h0, ALUControl}, 32'h6);
    check_eq("beq_t", {29'h0, RegWrite, MemWrite, retire}, 32'b001);
    step();
    Zero = 1'b0;
    check_eq("beq_t_pc", pc, 32'h10);
    fetch(32'h1000_FFFF);
    step();
    check_eq("beq_n", {29'h0, RegWrite, MemWrite, retire}, 32'b001);
    step();
    check_eq("beq_n_pc", pc, 32'h14);
    fetch(32'h0800_0040);
    check_eq("j2_retire", {31'h0, retire}, 32'h1);
    step();
    check_eq("j2_pc", pc, 32'h100);

    // ---------------- test 4: fetch stall, then reset mid-WRITEBACK
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq($sformatf("stall_req_%0d", i), {31'h0, instr_req}, 32'h1);
      check_eq($sformatf("stall_pc_%0d", i), pc, 32'h100);
    end
    check_eq("stall_ir", instruction, 32'h0800_0040);
    fetch(32'h0022_1820);
    check_eq("stall_load_ir", instruction, 32'h0022_1820);
    step();
    step();
    check_eq("wb_before_rst", {31'h0, RegWrite}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("wb_rst_rw", {31'h0, RegWrite}, 32'h0);
    check_eq("wb_rst_pc", pc, 32'h0);
    check_eq("wb_rst_ir", instruction, 32'h0);
    step();
    rst = 1'b0;

    // ---------------- test 5: illegal opcode, skip vs halt
    fetch(32'hFC00_0000);
    check_eq("ill_pulse", {31'h0, illegal_op}, 32'h1);
    check_eq("ill_h_pulse", {31'h0, h_illegal_op}, 32'h1);
    check_eq("ill_retire", {30'h0, retire, h_retire}, 32'h0);
    step();
    check_eq("ill_pc", pc, 32'h4);
    check_eq("ill_req", {31'h0, instr_req}, 32'h1);
    check_eq("ill_pulse_end", {31'h0, illegal_op}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("halt_req_%0d", i), {31'h0, h_instr_req}, 32'h0);
      check_eq($sformatf("halt_pc_%0d", i), h_pc, 32'h0);
      step();
    end
    fetch(32'h0022_1821);
    check_eq("ill_funct_pulse", {31'h0, illegal_op}, 32'h1);
    check_eq("halt_strobes", {29'h0, h_RegWrite, h_MemWrite, h_retire}, 32'h0);
    step();
    check_eq("ill_funct_pc", pc, 32'h8);
    do_reset();
    #1;
    check_eq("halt_exit_req", {31'h0, h_instr_req}, 32'h1);
    check_eq("halt_exit_pc", h_pc, 32'h0);

`ifdef MIPS_CTRL_PERF_EN
    // ---------------- test 6: three back-to-back adds
    do_reset();
    instr_valid = 1'b1;
    instr_rdata = 32'h0022_1820;
    for (int i = 0; i < 11; i++) step();
    check_eq("perf_third_retire", {31'h0, retire}, 32'h1);
    step();
    check_eq("perf_retired", retired_count, 32'd3);
    check_eq("perf_cycles", cycle_count, 32'd12);
    instr_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
